adc_scan_sequencer: RTL and testbench

- Scheduler in front of one adc045 converter instance; its outputs drive the converter's sync, wreg_command and channel_choice inputs.
- Walks a programmable scan list of up to 4 entries, one pass per period tick.
- Returns each 24-bit result on a valid/ready stream, tagged with entry index and channel.
- Flags missed deadlines, stalls and dropped results in sticky status bits.

---
 rtl/adc_seq_pkg.sv | 31 +++
 rtl/adc_seq_tick_gen.sv | 22 ++
 rtl/adc_scan_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Holds the sequencer state encoding, scan-table field positions and converter channel selections.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_NEXT
    } seq_state_t;

    localparam int CHOICE_MSB = 15;
    localparam int CHOICE_LSB = 14;
    localparam int WREG_MSB   = 13;

    localparam logic [1:0] CH_BOTH0 = 2'd0;
    localparam logic [1:0] CH1      = 2'd1;
    localparam logic [1:0] CH2      = 2'd2;
    localparam logic [1:0] CH_BOTH3 = 2'd3;

    // Both-channel selections return two words; single-channel selections return one.
    function automatic logic [1:0] words_expected(input logic [1:0] choice);
        case (choice)
            CH_BOTH0, CH_BOTH3: words_expected = 2'd2;
            CH1, CH2:           words_expected = 2'd1;
            default:            words_expected = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/adc_seq_tick_gen.sv
// Free-running scan period generator.
// Produces a one-cycle tick every PERIOD_CYCLES clocks.
module adc_seq_tick_gen #(
    parameter int PERIOD_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (tick) count <= '0;
        else           count <= count + 1'b1;
    end
endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan scheduler in front of one adc045 converter: walks the scan table once per
// period tick, strobes sync per entry and returns tagged results on a 1-deep valid/ready register.
//
//   state        | meaning
//   ST_IDLE      | scanning disabled
//   ST_WAIT_TICK | armed, waiting for the next period tick
//   ST_ISSUE     | load converter command for entry idx, start sync pulse
//   ST_WAIT_DATA | collecting result words for entry idx, timeout running
//   ST_NEXT      | advance to next entry or finish the scan
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int PERIOD_CYCLES  = 12000,
    parameter int SYNC_HOLD      = 8,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic [1:0]  cfg_count,
    input  logic        clear_status,
    output logic        adc_sync,
    output logic [13:0] adc_wreg,
    output logic [1:0]  adc_channel_choice,
    input  logic        adc_busy,
    input  logic [23:0] adc_data,
    input  logic        adc_channel,
    input  logic        adc_rd_en,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic [1:0]  res_index,
    output logic        res_channel,
    output logic        scan_done,
    output logic        overrun,
    output logic        timeout,
    output logic        scan_late
);
    localparam int SW = $clog2(SYNC_HOLD);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SYNC_LOAD = SW'(SYNC_HOLD - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state, state_nxt;
    logic          tick;
    logic [15:0]   scan_table [4];
    logic [1:0]    idx, last_idx;
    logic [1:0]    word_cnt, words_exp;
    logic [SW-1:0] sync_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          do_issue, do_done, tmo_hit;
    logic          capture, pop, late_evt;
    logic          unused_busy;

    // Completion is inferred from rd_en counts alone; busy is not needed.
    assign unused_busy = adc_busy;

    adc_seq_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign capture  = adc_rd_en && (state == ST_WAIT_DATA) && (word_cnt != words_exp);
    assign pop      = res_valid && res_ready;
    assign late_evt = tick && (state != ST_IDLE) && (state != ST_WAIT_TICK);

    always_comb begin
        state_nxt = state;
        do_issue  = 1'b0;
        do_done   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (tick)         state_nxt = ST_ISSUE;
                else if (!enable) state_nxt = ST_IDLE;
            end
            ST_ISSUE: begin
                do_issue  = 1'b1;
                state_nxt = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (word_cnt == words_exp) begin
                    state_nxt = ST_NEXT;
                end else if (tmo_cnt == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx < last_idx) begin
                    state_nxt = ST_ISSUE;
                end else begin
                    do_done   = 1'b1;
                    state_nxt = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) scan_table[i] <= '0;
        end else if (cfg_we) begin
            scan_table[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx                <= '0;
            last_idx           <= '0;
            adc_sync           <= 1'b0;
            adc_wreg           <= '0;
            adc_channel_choice <= '0;
            words_exp          <= '0;
            word_cnt           <= '0;
            sync_cnt           <= '0;
            tmo_cnt            <= '0;
            scan_done          <= 1'b0;
        end else begin
            scan_done <= do_done;
            if (state == ST_WAIT_TICK && tick) begin
                idx      <= '0;
                last_idx <= cfg_count;
            end else if (state == ST_NEXT && idx < last_idx) begin
                idx <= idx + 1'b1;
            end
            if (do_issue) begin
                adc_wreg           <= scan_table[idx][WREG_MSB:0];
                adc_channel_choice <= scan_table[idx][CHOICE_MSB:CHOICE_LSB];
                words_exp          <= words_expected(scan_table[idx][CHOICE_MSB:CHOICE_LSB]);
                adc_sync           <= 1'b1;
                sync_cnt           <= SYNC_LOAD;
                word_cnt           <= '0;
                tmo_cnt            <= TMO_LOAD;
            end else begin
                if (adc_sync) begin
                    if (sync_cnt == '0) adc_sync <= 1'b0;
                    else                sync_cnt <= sync_cnt - 1'b1;
                end
                if (state == ST_WAIT_DATA && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
                if (capture) word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // A capture always wins over a pop: the new word replaces whatever was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_index   <= '0;
            res_channel <= 1'b0;
        end else if (capture) begin
            res_valid   <= 1'b1;
            res_data    <= adc_data;
            res_index   <= idx;
            res_channel <= adc_channel;
        end else if (pop) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            scan_late <= 1'b0;
        end else begin
            if (capture && res_valid && !res_ready) overrun <= 1'b1;
            else if (clear_status)                  overrun <= 1'b0;
            if (tmo_hit)           timeout <= 1'b1;
            else if (clear_status) timeout <= 1'b0;
            if (late_evt)          scan_late <= 1'b1;
            else if (clear_status) scan_late <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer with a transaction-level converter model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_adc_scan_sequencer;
    localparam int PERIOD = 50;
    localparam int HOLD   = 8;
    localparam int TMO    = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable, cfg_we, clear_status, res_ready;
    logic [1:0]  cfg_addr, cfg_count;
    logic [15:0] cfg_data;
    logic        adc_sync, res_valid, res_channel, scan_done, overrun, timeout, scan_late;
    logic [13:0] adc_wreg;
    logic [1:0]  adc_channel_choice, res_index;
    logic        adc_busy, adc_channel, adc_rd_en;
    logic [23:0] adc_data, res_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit running = 0;

    logic [15:0] tbl_m [4];
    int          model_idx = -1;
    int          model_last = 0;
    bit          silent [4];
    int          conv_gap = 2;
    logic [15:0] word_seq = 16'd1;
    logic [26:0] exp_q [$];
    bit          exp_overrun = 0;

    int          rise_cnt = 0, done_cnt = 0;
    int          rise_log [$];
    int          first_rise_log [$];
    int          done_log [$];
    logic [1:0]  choice_log [$];
    logic [23:0] pop_data [$];
    logic [1:0]  pop_idx [$];
    logic        pop_ch [$];
    int          pop_cyc [$];

    adc_scan_sequencer #(
        .PERIOD_CYCLES  (PERIOD),
        .SYNC_HOLD      (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .cfg_we             (cfg_we),
        .cfg_addr           (cfg_addr),
        .cfg_data           (cfg_data),
        .cfg_count          (cfg_count),
        .clear_status       (clear_status),
        .adc_sync           (adc_sync),
        .adc_wreg           (adc_wreg),
        .adc_channel_choice (adc_channel_choice),
        .adc_busy           (adc_busy),
        .adc_data           (adc_data),
        .adc_channel        (adc_channel),
        .adc_rd_en          (adc_rd_en),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .res_index          (res_index),
        .res_channel        (res_channel),
        .scan_done          (scan_done),
        .overrun            (overrun),
        .timeout            (timeout),
        .scan_late          (scan_late)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) if (running) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int a, input logic [1:0] ch, input logic [13:0] wr);
        cfg_we   = 1'b1;
        cfg_addr = a[1:0];
        cfg_data = {ch, wr};
        tbl_m[a] = {ch, wr};
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic wait_rise(input string name);
        int start;
        int n;
        start = rise_cnt;
        n = 0;
        while (rise_cnt == start && n < 400) begin
            step(1);
            n++;
        end
        chk(name, rise_cnt != start, 1);
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 600) begin
            step(1);
            n++;
        end
        chk(name, done_cnt != start, 1);
    endtask

    task automatic clear_logs();
        pop_data.delete();
        pop_idx.delete();
        pop_ch.delete();
        pop_cyc.delete();
        choice_log.delete();
        rise_log.delete();
        first_rise_log.delete();
        done_log.delete();
    endtask

    // Per-cycle output monitor: command checks on each sync rise, result checks on each pop.
    initial begin : monitor
        logic        sp;
        int          hi;
        int          k;
        logic [26:0] w;
        sp = 1'b0;
        hi = 0;
        forever begin
            @(negedge clk);
            if (running) begin
                if (adc_sync && !sp) begin
                    rise_cnt++;
                    rise_log.push_back(cyc);
                    model_idx++;
                    chk("entries per scan", model_idx <= model_last, 1);
                    k = model_idx % 4;
                    if (model_idx == 0) begin
                        first_rise_log.push_back(cyc);
                        chk("scan start phase", cyc % PERIOD, 1);
                    end
                    chk("adc_wreg", adc_wreg, tbl_m[k][13:0]);
                    chk("adc_channel_choice", adc_channel_choice, tbl_m[k][15:14]);
                    choice_log.push_back(adc_channel_choice);
                end
                if (adc_sync) begin
                    hi++;
                end else if (sp) begin
                    chk("sync hold length", hi, HOLD);
                    hi = 0;
                end
                if (res_valid && res_ready) begin
                    chk("result expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("result word", {res_data, res_index, res_channel}, w);
                        pop_data.push_back(res_data);
                        pop_idx.push_back(res_index);
                        pop_ch.push_back(res_channel);
                        pop_cyc.push_back(cyc);
                    end
                end
                if (scan_done) begin
                    done_cnt++;
                    done_log.push_back(cyc);
                    model_idx = -1;
                end
                sp = adc_sync;
            end
        end
    end

    // Converter model: after each sync falls, returns the words its channel choice implies.
    initial begin : converter
        logic        sync_q;
        int          this_idx;
        int          n;
        logic [1:0]  choice;
        logic        ch;
        logic [26:0] w;
        sync_q      = 1'b0;
        adc_rd_en   = 1'b0;
        adc_busy    = 1'b0;
        adc_data    = '0;
        adc_channel = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sync_q && !adc_sync) begin
                this_idx = model_idx;
                choice   = adc_channel_choice;
                n        = (choice == 2'd1 || choice == 2'd2) ? 1 : 2;
                if (this_idx >= 0 && this_idx < 4 && !silent[this_idx]) begin
                    adc_busy = 1'b1;
                    step(2);
                    for (int j = 0; j < n; j++) begin
                        ch = (n == 2) ? (j == 1) : (choice == 2'd2);
                        w  = {8'hA0, word_seq, this_idx[1:0], ch};
                        adc_data    = {8'hA0, word_seq};
                        adc_channel = ch;
                        adc_rd_en   = 1'b1;
                        if (!res_ready && exp_q.size() > 0) begin
                            exp_q[exp_q.size() - 1] = w;
                            exp_overrun = 1;
                        end else begin
                            exp_q.push_back(w);
                        end
                        word_seq++;
                        step(1);
                        adc_rd_en = 1'b0;
                        step(conv_gap);
                    end
                    adc_busy = 1'b0;
                end
            end
            sync_q = adc_sync;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d;
        int t;
        enable       = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
        cfg_count    = '0;
        clear_status = 1'b0;
        res_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tbl_m[i]  = '0;
            silent[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        running = 1;

        @(negedge clk);
        chk("reset adc_sync", adc_sync, 0);
        chk("reset adc_wreg", adc_wreg, 0);
        chk("reset adc_channel_choice", adc_channel_choice, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_data", res_data, 0);
        chk("reset scan_done", scan_done, 0);
        chk("reset flags", {overrun, timeout, scan_late}, 0);
        step(1);

        // Single both-channel entry; enable dropped mid-scan so it ends in IDLE.
        clear_logs();
        cfg_write(0, 2'd0, 14'h1234);
        cfg_count = 2'd0; model_last = 0;
        enable = 1'b1;
        wait_rise("T1 scan start");
        enable = 1'b0;
        wait_done("T1 scan done");
        step(4);
        chk("T1 result count", pop_data.size(), 2);
        chk("T1 word0 data", pop_data[0], 24'hA00001);
        chk("T1 word1 data", pop_data[1], 24'hA00002);
        chk("T1 word0 channel", pop_ch[0], 0);
        chk("T1 word1 channel", pop_ch[1], 1);
        chk("T1 word indices", {pop_idx[0], pop_idx[1]}, 0);
        chk("T1 adc_wreg held", adc_wreg, 14'h1234);
        chk("T1 scan_done cycles", done_cnt, 1);

        // Two single-channel entries.
        clear_logs();
        cfg_write(0, 2'd1, 14'h0AAA);
        cfg_write(1, 2'd2, 14'h0555);
        cfg_count = 2'd1; model_last = 1;
        enable = 1'b1;
        wait_rise("T2 scan start");
        enable = 1'b0;
        wait_done("T2 scan done");
        step(4);
        chk("T2 choice sequence", {choice_log[0], choice_log[1]}, 4'b0110);
        chk("T2 result count", pop_data.size(), 2);
        chk("T2 word0", {pop_data[0], pop_idx[0], pop_ch[0]}, {24'hA00003, 2'd0, 1'b0});
        chk("T2 word1", {pop_data[1], pop_idx[1], pop_ch[1]}, {24'hA00004, 2'd1, 1'b1});
        chk("T2 scan_done cycles", done_cnt, 2);

        // Consumer stalled: second word overwrites the first.
        clear_logs();
        res_ready = 1'b0;
        exp_overrun = 0;
        cfg_write(0, 2'd0, 14'h0042);
        cfg_count = 2'd0; model_last = 0;
        enable = 1'b1;
        wait_rise("T3 scan start");
        enable = 1'b0;
        wait_done("T3 scan done");
        step(2);
        chk("T3 model overrun", exp_overrun, 1);
        chk("T3 res_valid held", res_valid, 1);
        chk("T3 res_data newest", res_data, 24'hA00006);
        chk("T3 res_channel", res_channel, 1);
        chk("T3 overrun set", overrun, 1);
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        chk("T3 overrun cleared", overrun, 0);
        res_ready = 1'b1;
        step(3);
        chk("T3 drained word", pop_data[pop_data.size() - 1], 24'hA00006);
        chk("T3 queue empty", exp_q.size(), 0);

        // Back-to-back words: capture and pop in the same cycle.
        clear_logs();
        conv_gap = 0;
        cfg_write(0, 2'd3, 14'h3FFF);
        enable = 1'b1;
        wait_rise("T4 scan start");
        enable = 1'b0;
        wait_done("T4 scan done");
        step(4);
        conv_gap = 2;
        chk("T4 result count", pop_data.size(), 2);
        chk("T4 words", {pop_data[0], pop_data[1]}, {24'hA00007, 24'hA00008});
        chk("T4 consecutive pops", pop_cyc[1] - pop_cyc[0], 1);
        chk("T4 no overrun", overrun, 0);
        chk("T4 no scan_late", scan_late, 0);

        // Entry 0 never answers: timeout, then entry 1 still runs.
        clear_logs();
        silent[0] = 1;
        cfg_write(0, 2'd1, 14'h0101);
        cfg_write(1, 2'd2, 14'h0202);
        cfg_count = 2'd1; model_last = 1;
        enable = 1'b1;
        wait_rise("T5 scan start");
        enable = 1'b0;
        wait_done("T5 scan done");
        step(4);
        silent[0] = 0;
        d = rise_log[1] - rise_log[0];
        chk("T5 timeout spacing", (d >= TMO) && (d <= TMO + 4), 1);
        chk("T5 timeout flag", timeout, 1);
        chk("T5 scan_late flag", scan_late, 1);
        chk("T5 result count", pop_data.size(), 1);
        chk("T5 word", {pop_data[0], pop_idx[0], pop_ch[0]}, {24'hA00009, 2'd1, 1'b1});
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        chk("T5 flags cleared", {timeout, scan_late}, 0);

        // Four-entry scan longer than the period: late flag, no catch-up scan.
        clear_logs();
        for (int i = 0; i < 4; i++) cfg_write(i, 2'd0, 14'h0100 + 14'(i));
        cfg_count = 2'd3; model_last = 3;
        enable = 1'b1;
        wait_done("T6 first scan done");
        wait_rise("T6 second scan start");
        enable = 1'b0;
        wait_done("T6 second scan done");
        step(4);
        chk("T6 scan_late flag", scan_late, 1);
        d = done_log[0];
        t = d + ((PERIOD - 1 - (d % PERIOD)) + PERIOD) % PERIOD;
        chk("T6 next scan start", first_rise_log[1], t + 2);
        chk("T6 result count", pop_data.size(), 16);
        chk("T6 first word", pop_data[0], 24'hA0000A);
        chk("final queue empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
